// File: rtl/mmio_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_pkg
// Purpose  : Register offsets and seven-segment decode shared by the MMIO
//            I/O controller and its scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_io_pkg;

  localparam logic [7:0] OFF_SW       = 8'h00;
  localparam logic [7:0] OFF_LED      = 8'h04;
  localparam logic [7:0] OFF_SEG_DATA = 8'h08;
  localparam logic [7:0] OFF_SEG_CTRL = 8'h0C;
  localparam logic [7:0] OFF_SW_EDGE  = 8'h10;
  localparam logic [7:0] OFF_IRQ_MASK = 8'h14;

  // Active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_io_ctrl_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan
// Purpose  : Time-multiplexed N-digit seven-segment driver with registered,
//            active-low segment and digit-enable outputs.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan
  import mmio_io_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 8192
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   seg_data,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     dp,
  output logic [7:0]            segment_led,
  output logic [DIGITS-1:0]     seg_en
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_seg_led;
  logic [DIGITS-1:0] r_seg_en;
  logic [3:0]        w_nib;
  logic              w_dp;
  logic              w_wrap;
  logic [DIGITS-1:0] w_en;

  assign w_wrap = (r_cnt == CNT_W'(SCAN_DIV - 1));

  // Nibble, dp and blank of the active digit are all picked in the same cycle.
  // A blanked digit leaves its enable high, so every enable stays high.
  always_comb begin
    w_nib = '0;
    w_dp  = 1'b0;
    w_en  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib   = seg_data[4*i +: 4];
        w_dp    = dp[i];
        w_en[i] = blank[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_seg_led <= '1;
      r_seg_en  <= '1;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      if (w_wrap) begin
        r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end
      r_seg_led <= ~{w_dp, hex7(w_nib)};
      r_seg_en  <= w_en;
    end
  end

  assign segment_led = r_seg_led;
  assign seg_en      = r_seg_en;

endmodule
`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_ctrl
// Purpose  : Memory-mapped switch/LED/seven-segment peripheral for the MIPS
//            data bus. Optional IRQ_MASK register and irq output: IO_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_io_ctrl
  import mmio_io_pkg::*;
#(
  parameter int SW_W     = 24,
  parameter int LED_W    = 24,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 8192,
  parameter int DEB_DIV  = 65536
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_sel,
  input  logic [7:0]        addr,
  input  logic              wen,
  input  logic              ren,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   switch_i,
  output logic [LED_W-1:0]  led_o,
  output logic [7:0]        segment_led,
  output logic [DIGITS-1:0] seg_en,
  output logic              irq
);

  localparam int DEB_W = $clog2(DEB_DIV);

  logic [7:0]        w_off;
  logic              w_wr;
  logic              w_rd;
  logic              w_deb_tick;
  logic [SW_W-1:0]   r_sync1, r_sync2, r_deb_prev, r_sw_deb, r_sw_edge;
  logic [SW_W-1:0]   w_agree, w_deb_next, w_edge_clr;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [LED_W-1:0]  r_led;
  logic [31:0]       r_seg_data, r_rdata, w_rd_val, w_seg_ctrl;
  logic [DIGITS-1:0] r_blank, r_dp;

  assign w_off      = addr & 8'hFC;
  assign w_wr       = io_sel & wen;
  assign w_rd       = io_sel & ren;
  assign w_deb_tick = (r_deb_cnt == DEB_W'(DEB_DIV - 1));

  // A bit follows the synchronised input only when two consecutive ticks agree.
  assign w_agree    = ~(r_sync2 ^ r_deb_prev);
  assign w_deb_next = w_deb_tick ? ((r_sw_deb & ~w_agree) | (r_sync2 & w_agree))
                                 : r_sw_deb;
  assign w_edge_clr = (w_wr && (w_off == OFF_SW_EDGE)) ? wdata[SW_W-1:0] : '0;

  always_comb begin
    w_seg_ctrl               = '0;
    w_seg_ctrl[DIGITS-1:0]   = r_blank;
    w_seg_ctrl[8 +: DIGITS]  = r_dp;
  end

`ifdef IO_IRQ_EN
  logic [SW_W-1:0] r_irq_mask;
  logic            r_irq;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_IRQ_MASK)) r_irq_mask <= wdata[SW_W-1:0];
      r_irq <= |(r_sw_edge & r_irq_mask);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  // Built from current state, so a same-cycle write returns the old value.
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      OFF_SW:       w_rd_val = 32'(r_sw_deb);
      OFF_LED:      w_rd_val = 32'(r_led);
      OFF_SEG_DATA: w_rd_val = r_seg_data;
      OFF_SEG_CTRL: w_rd_val = w_seg_ctrl;
      OFF_SW_EDGE:  w_rd_val = 32'(r_sw_edge);
`ifdef IO_IRQ_EN
      OFF_IRQ_MASK: w_rd_val = 32'(r_irq_mask);
`else
      OFF_IRQ_MASK: w_rd_val = '0;
`endif
      default:      w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb_cnt  <= '0;
      r_deb_prev <= '0;
      r_sw_deb   <= '0;
      r_sw_edge  <= '0;
      r_led      <= '0;
      r_seg_data <= '0;
      r_blank    <= '0;
      r_dp       <= '0;
      r_rdata    <= '0;
    end else begin
      r_sync1   <= switch_i;
      r_sync2   <= r_sync1;
      r_deb_cnt <= w_deb_tick ? '0 : r_deb_cnt + DEB_W'(1);
      if (w_deb_tick) r_deb_prev <= r_sync2;
      r_sw_deb  <= w_deb_next;
      // Set term is OR'd after the clear so a coincident rise survives.
      r_sw_edge <= (r_sw_edge & ~w_edge_clr) | (w_deb_next & ~r_sw_deb);
      if (w_wr) begin
        case (w_off)
          OFF_LED:      r_led      <= wdata[LED_W-1:0];
          OFF_SEG_DATA: r_seg_data <= wdata;
          OFF_SEG_CTRL: begin
            r_blank <= wdata[DIGITS-1:0];
            r_dp    <= wdata[8 +: DIGITS];
          end
          default: ;
        endcase
      end
      if (w_rd) r_rdata <= w_rd_val;
    end
  end

  seg_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clock       (clock),
    .reset       (reset),
    .seg_data    (r_seg_data[4*DIGITS-1:0]),
    .blank       (r_blank),
    .dp          (r_dp),
    .segment_led (segment_led),
    .seg_en      (seg_en)
  );

  assign rdata = r_rdata;
  assign led_o = r_led;

endmodule
`default_nettype wire
